// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// States, cause codes and the watchdog limit.
package exc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAISE,
    S_HANDLER,
    S_FAULT
  } state_e;

  localparam logic [3:0] EST_NONE  = 4'b0000;
  localparam logic [3:0] EST_IRQ   = 4'b0001;
  localparam logic [3:0] EST_INSTR = 4'b0010;
  localparam logic [3:0] EST_FATAL = 4'b1111;

  localparam logic [3:0] WDOG_MAX = 4'hF;

endpackage

// File: rtl/exc_wdog.sv
// Acknowledge watchdog for the RAISE phase.
// Counts unacknowledged cycles; expired at WDOG_MAX.
module exc_wdog
  import exc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'h0;
    end else if (enable) begin
      cnt_d = cnt_q + 4'h1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WDOG_MAX);

endmodule

// File: rtl/exc_controller.sv
// Exception controller: IRQ / invalid-opcode entry,
// handler tracking, ERET return and fatal halt.
module exc_controller
  import exc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ExtIRQ,
  input  logic       NotAnInstr,
  input  logic       Eret,
  input  logic       ExcAck,
  output logic       Exc,
  output logic       ExtIAck,
  output logic       EPCWrite,
  output logic [3:0] EStatus,
  output logic       InHandler,
  output logic       Halt
);

  state_e     state_q, state_d;
  logic [3:0] estatus_q, estatus_d;
  logic       first_q, first_d;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  exc_wdog u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Next state, cause code and watchdog control
  always_comb begin
    state_d   = state_q;
    estatus_d = estatus_q;
    first_d   = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (NotAnInstr) begin
          state_d   = S_RAISE;
          estatus_d = EST_INSTR;
          first_d   = 1'b1;
          wd_clear  = 1'b1;
        end else if (ExtIRQ) begin
          state_d   = S_RAISE;
          estatus_d = EST_IRQ;
          first_d   = 1'b1;
          wd_clear  = 1'b1;
        end
      end
      S_RAISE: begin
        if (ExcAck) begin
          state_d = S_HANDLER;
        end else if (wd_expired) begin
          state_d   = S_FAULT;
          estatus_d = EST_FATAL;
        end else begin
          wd_enable = 1'b1;
        end
      end
      S_HANDLER: begin
        if (Eret) begin
          state_d   = S_IDLE;
          estatus_d = EST_NONE;
        end else if (NotAnInstr) begin
          state_d   = S_FAULT;
          estatus_d = EST_FATAL;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d   = S_IDLE;
        estatus_d = EST_NONE;
      end
    endcase
  end

  // State and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      estatus_q <= EST_NONE;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      estatus_q <= estatus_d;
      first_q   <= first_d;
    end
  end

  assign Exc       = (state_q == S_RAISE);
  assign EPCWrite  = Exc && first_q;
  assign ExtIAck   = EPCWrite && (estatus_q == EST_IRQ);
  assign EStatus   = estatus_q;
  assign InHandler = (state_q == S_HANDLER);
  assign Halt      = (state_q == S_FAULT);

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller:
// directed vector table, watchdog sequences, random vs model.
module tb_exc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ExtIRQ = 1'b0;
  logic       NotAnInstr = 1'b0;
  logic       Eret = 1'b0;
  logic       ExcAck = 1'b0;
  logic       Exc, ExtIAck, EPCWrite, InHandler, Halt;
  logic [3:0] EStatus;

  exc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .NotAnInstr (NotAnInstr),
    .Eret       (Eret),
    .ExcAck     (ExcAck),
    .Exc        (Exc),
    .ExtIAck    (ExtIAck),
    .EPCWrite   (EPCWrite),
    .EStatus    (EStatus),
    .InHandler  (InHandler),
    .Halt       (Halt)
  );

  always #5 clk = ~clk;

  // input bits {reset, irq, nai, eret, ack}
  localparam logic [4:0] R = 5'b10000;
  localparam logic [4:0] I = 5'b01000;
  localparam logic [4:0] N = 5'b00100;
  localparam logic [4:0] E = 5'b00010;
  localparam logic [4:0] A = 5'b00001;
  localparam logic [4:0] Z = 5'b00000;

  // observed bits {exc, epc, iack, estatus, inh, halt}
  wire [8:0] obs = {Exc, EPCWrite, ExtIAck, EStatus, InHandler, Halt};

  typedef struct packed {
    logic [4:0] in;
    logic [8:0] exp;
  } vec_t;

  int total = 0;
  int bad = 0;

  // reference model: plain flags plus a cycle age
  bit         m_raise = 0;
  bit         m_hand = 0;
  bit         m_halt = 0;
  int         m_age = 0;
  logic [3:0] m_cause = 4'b0000;

  function automatic logic [8:0] o(
    input bit exc, input bit epc, input bit iack,
    input logic [3:0] est, input bit inh, input bit hlt);
    return {exc, epc, iack, est, inh, hlt};
  endfunction

  function automatic logic [8:0] model_exp();
    bit first;
    first = m_raise && (m_age == 1);
    return o(m_raise, first, first && (m_cause == 4'b0001),
             m_halt ? 4'b1111 : m_cause, m_hand, m_halt);
  endfunction

  task automatic model_update(input logic [4:0] v);
    if (v[4]) begin
      m_raise = 0; m_hand = 0; m_halt = 0;
      m_age = 0; m_cause = 4'b0000;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_raise) begin
      if (v[0]) begin
        m_raise = 0; m_hand = 1;
      end else if (m_age == 16) begin
        m_raise = 0; m_halt = 1; m_cause = 4'b1111;
      end else begin
        m_age++;
      end
    end else if (m_hand) begin
      if (v[1]) begin
        m_hand = 0; m_cause = 4'b0000;
      end else if (v[2]) begin
        m_hand = 0; m_halt = 1; m_cause = 4'b1111;
      end
    end else if (v[2] || v[3]) begin
      m_raise = 1; m_age = 1;
      m_cause = v[2] ? 4'b0010 : 4'b0001;
    end
  endtask

  task automatic step(input logic [4:0] v);
    {reset, ExtIRQ, NotAnInstr, Eret, ExcAck} = v;
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [8:0] got,
                       input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", nm, got, exp);
    end
  endtask

  vec_t tbl[25];

  initial begin
    tbl[0]  = '{R,         o(0,0,0,4'b0000,0,0)};
    tbl[1]  = '{I,         o(1,1,1,4'b0001,0,0)};
    tbl[2]  = '{I,         o(1,0,0,4'b0001,0,0)};
    tbl[3]  = '{I,         o(1,0,0,4'b0001,0,0)};
    tbl[4]  = '{I|A,       o(0,0,0,4'b0001,1,0)};
    tbl[5]  = '{I,         o(0,0,0,4'b0001,1,0)};
    tbl[6]  = '{I|E,       o(0,0,0,4'b0000,0,0)};
    tbl[7]  = '{I,         o(1,1,1,4'b0001,0,0)};
    tbl[8]  = '{A,         o(0,0,0,4'b0001,1,0)};
    tbl[9]  = '{E|N,       o(0,0,0,4'b0000,0,0)};
    tbl[10] = '{N|I,       o(1,1,0,4'b0010,0,0)};
    tbl[11] = '{A|I,       o(0,0,0,4'b0010,1,0)};
    tbl[12] = '{E|I,       o(0,0,0,4'b0000,0,0)};
    tbl[13] = '{I,         o(1,1,1,4'b0001,0,0)};
    tbl[14] = '{A|I,       o(0,0,0,4'b0001,1,0)};
    tbl[15] = '{N,         o(0,0,0,4'b1111,0,1)};
    tbl[16] = '{A|E,       o(0,0,0,4'b1111,0,1)};
    tbl[17] = '{R|I|N|E|A, o(0,0,0,4'b0000,0,0)};
    tbl[18] = '{I,         o(1,1,1,4'b0001,0,0)};
    tbl[19] = '{R|A,       o(0,0,0,4'b0000,0,0)};
    tbl[20] = '{A,         o(0,0,0,4'b0000,0,0)};
    tbl[21] = '{E,         o(0,0,0,4'b0000,0,0)};
    tbl[22] = '{N,         o(1,1,0,4'b0010,0,0)};
    tbl[23] = '{A,         o(0,0,0,4'b0010,1,0)};
    tbl[24] = '{E,         o(0,0,0,4'b0000,0,0)};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // ack on the 16th RAISE cycle still reaches HANDLER
    step(R);
    step(I);
    check("wd_c1", obs, o(1,1,1,4'b0001,0,0));
    for (int k = 2; k <= 16; k++) begin
      step(Z);
      check($sformatf("wd_keep%0d", k), obs, o(1,0,0,4'b0001,0,0));
    end
    step(A);
    check("wd_late_ack", obs, o(0,0,0,4'b0001,1,0));

    // 16 unacknowledged cycles then FAULT
    step(R);
    step(N);
    for (int k = 2; k <= 16; k++) begin
      step(Z);
      check($sformatf("wd_exc%0d", k), obs, o(1,0,0,4'b0010,0,0));
    end
    step(Z);
    check("wd_fault", obs, o(0,0,0,4'b1111,0,1));
    step(A|I);
    check("fault_hold", obs, o(0,0,0,4'b1111,0,1));
    step(R);
    check("fault_reset", obs, o(0,0,0,4'b0000,0,0));

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] v;
      v[4] = ($urandom_range(0, 99) < 2);
      v[3] = ($urandom_range(0, 2) == 0);
      v[2] = ($urandom_range(0, 9) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[0] = ($urandom_range(0, 9) == 0);
      step(v);
      check("rand", obs, model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
